// File: rtl/lpc_io_target_pkg.sv
// Shared definitions for the LPC I/O target: FSM encodings, default I/O map
// and the layout of the status byte.
package lpc_io_target_pkg;

  localparam logic [1:0] LPC_TGT_ST_IDLE    = 2'd0;
  localparam logic [1:0] LPC_TGT_ST_WR_ACK  = 2'd1;
  localparam logic [1:0] LPC_TGT_ST_RD_WAIT = 2'd2;
  localparam logic [1:0] LPC_TGT_ST_RD_ACK  = 2'd3;

  localparam logic [15:0] LPC_POST_ADDR_DEF    = 16'h0080;
  localparam logic [15:0] LPC_STATUS_ADDR_DEF  = 16'h0081;
  localparam logic [15:0] LPC_SCRATCH_BASE_DEF = 16'h0C00;
  localparam int          LPC_SCRATCH_NUM      = 4;

  localparam int LPC_STAT_OVF_BIT   = 7;
  localparam int LPC_STAT_EMPTY_BIT = 6;
  localparam int LPC_STAT_FULL_BIT  = 5;

  function automatic logic [7:0] lpc_status_byte(input logic       ovf,
                                                 input logic       empty,
                                                 input logic       full,
                                                 input logic [4:0] count);
    logic [7:0] s;
    s                     = {3'b000, count};
    s[LPC_STAT_OVF_BIT]   = ovf;
    s[LPC_STAT_EMPTY_BIT] = empty;
    s[LPC_STAT_FULL_BIT]  = full;
    return s;
  endfunction

endpackage

// File: rtl/lpc_io_target_fifo.sv
// Synchronous FIFO for POST-code capture; push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module lpc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage is deliberately not reset; only pointers and count are, and
  // the head output is gated while empty so nothing stale ever escapes.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  // NOTE: sequential state always uses <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign dout_o  = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O target: POST-code port with capture FIFO, status register and four
// scratch registers behind the front-end's write/read handshake.
module lpc_io_target
  import lpc_io_target_pkg::*;
#(
  parameter logic [15:0] POST_ADDR    = LPC_POST_ADDR_DEF,
  parameter logic [15:0] STATUS_ADDR  = LPC_STATUS_ADDR_DEF,
  parameter logic [15:0] SCRATCH_BASE = LPC_SCRATCH_BASE_DEF,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          RESP_DELAY   = 0
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [15:0] lpc_addr_i,
  inout  wire  [7:0]  lpc_data_io,
  input  logic        lpc_data_wr_i,
  output logic        lpc_wr_done_o,
  input  logic        lpc_data_req_i,
  output logic        lpc_data_rd_o,
  output logic        post_valid_o,
  output logic [7:0]  post_data_o,
  input  logic        post_ready_i,
  output logic        overflow_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [15:0]   addr_q;
  logic [3:0]    dly_cnt;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    last_post;
  logic [7:0]    scratch [LPC_SCRATCH_NUM];
  logic          overflow;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          wr_start, rd_commit, post_wr, post_pop, post_drop, clr_ovf;
  logic [15:0]   wr_off, rd_off;
  logic [7:0]    wr_data;

  assign wr_data   = lpc_data_io;
  assign wr_start  = (state == LPC_TGT_ST_IDLE) && lpc_data_wr_i;
  assign rd_commit = (state == LPC_TGT_ST_RD_WAIT) && lpc_data_req_i && (dly_cnt == 4'd0);
  assign post_wr   = wr_start && (lpc_addr_i == POST_ADDR);
  assign post_pop  = post_valid_o && post_ready_i;
  assign post_drop = post_wr && fifo_full && !post_pop;
  assign clr_ovf   = rd_commit && (addr_q == STATUS_ADDR);
  assign wr_off    = lpc_addr_i - SCRATCH_BASE;
  assign rd_off    = addr_q - SCRATCH_BASE;

  lpc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_post_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (post_wr),
    .din_i   (wr_data),
    .pop_i   (post_ready_i),
    .dout_o  (post_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign post_valid_o = !fifo_empty;

  always_comb begin
    // NOTE: default first so every path assigns rd_data_d and no latch forms.
    rd_data_d = 8'hFF;
    if (addr_q == POST_ADDR)
      rd_data_d = last_post;
    else if (addr_q == STATUS_ADDR)
      rd_data_d = lpc_status_byte(overflow, fifo_empty, fifo_full, 5'(fifo_count));
    else if (rd_off[15:2] == '0)
      rd_data_d = scratch[rd_off[1:0]];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= LPC_TGT_ST_IDLE;
      addr_q    <= '0;
      dly_cnt   <= '0;
      rd_data_q <= '0;
    end else begin
      case (state)
        LPC_TGT_ST_IDLE:
          if (lpc_data_wr_i) begin
            addr_q <= lpc_addr_i;
            state  <= LPC_TGT_ST_WR_ACK;
          end else if (lpc_data_req_i) begin
            addr_q  <= lpc_addr_i;
            dly_cnt <= 4'(RESP_DELAY);
            state   <= LPC_TGT_ST_RD_WAIT;
          end
        LPC_TGT_ST_WR_ACK:
          if (!lpc_data_wr_i) state <= LPC_TGT_ST_IDLE;
        LPC_TGT_ST_RD_WAIT:
          // An aborted read leaves without committing any side effect.
          if (!lpc_data_req_i) begin
            state <= LPC_TGT_ST_IDLE;
          end else if (dly_cnt == 4'd0) begin
            rd_data_q <= rd_data_d;
            state     <= LPC_TGT_ST_RD_ACK;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        LPC_TGT_ST_RD_ACK:
          if (!lpc_data_req_i) state <= LPC_TGT_ST_IDLE;
        default: state <= LPC_TGT_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      last_post <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < LPC_SCRATCH_NUM; i++) scratch[i] <= '0;
    end else begin
      if (post_wr) last_post <= wr_data;
      if (wr_start && (wr_off[15:2] == '0)) scratch[wr_off[1:0]] <= wr_data;
      // A drop in the same cycle as a status-read commit keeps overflow set.
      if (post_drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign overflow_o    = overflow;
  assign lpc_wr_done_o = (state == LPC_TGT_ST_WR_ACK);
  assign lpc_data_rd_o = (state == LPC_TGT_ST_RD_ACK);
  assign lpc_data_io   = lpc_data_rd_o ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: POST capture/drain, overflow and status,
// scratch map, read latency/abort and asynchronous reset.
module tb_lpc_io_target;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] addr;
  logic [7:0]  wdat;
  logic        drv, wr, req, ready;
  wire  [7:0]  bus;
  logic        wr_done, rd_o, pvalid, ovf;
  logic [7:0]  pdata;

  logic        req3;
  wire  [7:0]  bus3;
  logic        wr_done3, rd3, pvalid3, ovf3;
  logic [7:0]  pdata3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign bus = drv ? wdat : 8'hzz;

  lpc_io_target dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .lpc_addr_i     (addr),
    .lpc_data_io    (bus),
    .lpc_data_wr_i  (wr),
    .lpc_wr_done_o  (wr_done),
    .lpc_data_req_i (req),
    .lpc_data_rd_o  (rd_o),
    .post_valid_o   (pvalid),
    .post_data_o    (pdata),
    .post_ready_i   (ready),
    .overflow_o     (ovf)
  );

  lpc_io_target #(.RESP_DELAY(3)) dut_d3 (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .lpc_addr_i     (16'h0C01),
    .lpc_data_io    (bus3),
    .lpc_data_wr_i  (1'b0),
    .lpc_wr_done_o  (wr_done3),
    .lpc_data_req_i (req3),
    .lpc_data_rd_o  (rd3),
    .post_valid_o   (pvalid3),
    .post_data_o    (pdata3),
    .post_ready_i   (1'b0),
    .overflow_o     (ovf3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lpc_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdat = d; drv = 1'b1; wr = 1'b1;
    tick;
    check("wr_done_high", wr_done, 1);
    wr = 1'b0; drv = 1'b0;
    tick;
    check("wr_done_low", wr_done, 0);
  endtask

  task automatic lpc_read(input logic [15:0] a, output logic [7:0] d, output int lat);
    addr = a; req = 1'b1; lat = 0;
    while (!rd_o && lat < 20) begin
      tick;
      lat++;
    end
    check("rd_ack_seen", rd_o, 1);
    d = bus;
    req = 1'b0;
    tick;
    check("rd_ack_low", rd_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int         lat;

    nrst = 1'b0; addr = '0; wdat = '0; drv = 1'b0; wr = 1'b0; req = 1'b0;
    ready = 1'b0; req3 = 1'b0;
    tick; tick;
    check("rst_wr_done", wr_done, 0);
    check("rst_rd", rd_o, 0);
    check("rst_pvalid", pvalid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_pdata", pdata, 8'h00);
    nrst = 1'b1;
    tick;

    // POST capture and drain
    lpc_write(16'h0080, 8'hA5);
    check("post_valid_after_push", pvalid, 1);
    lpc_write(16'h0080, 8'h3C);
    check("head_a5", pdata, 8'hA5);
    ready = 1'b1;
    tick;
    check("head_3c", pdata, 8'h3C);
    tick;
    check("drained_valid", pvalid, 0);
    ready = 1'b0;
    lpc_read(16'h0080, rd, lat);
    check("last_post_3c", rd, 8'h3C);
    check("rd_latency_d0", lat, 2);
    lpc_read(16'h0081, rd, lat);
    check("status_empty", rd, 8'h40);

    // Overflow: 17 writes into depth 16, 0x10 dropped
    for (int i = 0; i < 17; i++) lpc_write(16'h0080, 8'(i));
    check("ovf_set", ovf, 1);
    addr = 16'h0081; req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    check("abort_no_ack", rd_o, 0);
    check("abort_keeps_ovf", ovf, 1);
    lpc_read(16'h0081, rd, lat);
    check("status_ovf_full", rd, 8'hB0);
    check("ovf_cleared", ovf, 0);
    lpc_read(16'h0081, rd, lat);
    check("status_full", rd, 8'h30);
    lpc_read(16'h0080, rd, lat);
    check("last_post_dropped", rd, 8'h10);

    // Push and pop in the same cycle while full
    addr = 16'h0080; wdat = 8'hEE; drv = 1'b1; wr = 1'b1; ready = 1'b1;
    tick;
    ready = 1'b0; wr = 1'b0; drv = 1'b0;
    tick;
    check("pushpop_ovf", ovf, 0);
    lpc_read(16'h0081, rd, lat);
    check("pushpop_status", rd, 8'h30);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_head", pdata, (i < 15) ? 8'(i + 1) : 8'hEE);
      tick;
    end
    ready = 1'b0;
    check("drain_empty", pvalid, 0);

    // Scratch map and unmapped addresses
    lpc_write(16'h0C02, 8'h5A);
    lpc_write(16'h1234, 8'h77);
    lpc_read(16'h0C02, rd, lat);
    check("scratch2", rd, 8'h5A);
    lpc_read(16'h0C00, rd, lat);
    check("scratch0_reset", rd, 8'h00);
    lpc_read(16'h0C05, rd, lat);
    check("unmapped_ff", rd, 8'hFF);
    lpc_read(16'h1234, rd, lat);
    check("unmapped_write_ff", rd, 8'hFF);

    // RESP_DELAY=3: req sampled at edge N, ack after edge N+4
    req3 = 1'b1; lat = 0;
    while (!rd3 && lat < 20) begin
      tick;
      lat++;
    end
    check("d3_latency", lat, 5);
    check("d3_data", bus3, 8'h00);
    req3 = 1'b0;
    tick;
    check("d3_ack_low", rd3, 0);
    req3 = 1'b1;
    tick; tick;
    req3 = 1'b0;
    tick;
    check("d3_abort", rd3, 0);
    tick; tick; tick;
    check("d3_abort_late", rd3, 0);

    // Asynchronous reset during WR_ACK
    addr = 16'h0080; wdat = 8'h11; drv = 1'b1; wr = 1'b1;
    tick;
    check("pre_rst_wr_done", wr_done, 1);
    check("pre_rst_pvalid", pvalid, 1);
    #2 nrst = 1'b0;
    #1;
    check("async_wr_done", wr_done, 0);
    check("async_pvalid", pvalid, 0);
    check("async_pdata", pdata, 8'h00);
    check("async_rd", rd_o, 0);
    wr = 1'b0; drv = 1'b0;
    tick;
    nrst = 1'b1;
    tick;
    lpc_read(16'h0C02, rd, lat);
    check("rst_scratch", rd, 8'h00);
    lpc_read(16'h0080, rd, lat);
    check("rst_last_post", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
